// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and multiplier sequencer states.
// Imported by the multiplier sequencer and its adder.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int MULT_ITER = 32;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/add32.sv
// 32-bit combinational adder shared with the ALU.
// No carry-out; callers derive one from the operand and sum MSBs.
module add32
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mult_seq.sv
// Unsigned 32x32->64 shift-add multiplier sequencer (MULTU).
// One add32 step per clock; product lands in HI/LO.
module mult_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  if (WIDTH != WORD_W) begin : g_bad_width
    $error("mult_seq: WIDTH must equal 32");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("mult_seq: CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MULT_ITER - 1);

  ms_state_e        state_q, state_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             carry;

  assign add_a = acc_hi_q;
  assign add_b = acc_lo_q[0] ? mreg_q : '0;

  add32 u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1])
               | ((add_a[WIDTH-1] | add_b[WIDTH-1])
                  & ~add_sum[WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    mreg_d   = mreg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MS_IDLE, MS_DONE: begin
        if (start) begin
          mreg_d   = mcand;
          acc_hi_d = '0;
          acc_lo_d = mplier;
          count_d  = '0;
          state_d  = MS_RUN;
        end else begin
          state_d  = MS_IDLE;
        end
      end
      MS_RUN: begin
        // Low 64 bits of {carry,sum,acc_lo} >> 1.
        acc_hi_d = {carry, add_sum[WIDTH-1:1]};
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d = MS_DONE;
          hi_d    = acc_hi_d;
          lo_d    = acc_lo_d;
        end
      end
      default: state_d = MS_IDLE;
    endcase
    busy_d = (state_d == MS_RUN);
    done_d = (state_d == MS_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      mreg_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreg_q   <= mreg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle unsigned 32x32->64 multiplier sequencer (MULTU path) for the MIPS processor.
- Reuses one existing add32 instance as its only adder and drives it one shift-add step per clock.
- Writes the product to HI/LO result registers.
- Sits beside the ALU. The control unit starts it and stalls on busy until done.

Parameters:
- WIDTH, 32, operand width. Fixed by add32; any other value is a compile-time error.
- CNT_W, 6, iteration counter width. Must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled every cycle, accepted only in IDLE or DONE
- mcand  in  32  multiplicand, captured on accepted start
- mplier  in  32  multiplier, captured on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- hi  out  32  product[63:32], registered
- lo  out  32  product[31:0], registered

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Internal acc, mreg and count cleared.
  - Reset mid-RUN aborts the operation; no done is issued.
- States: IDLE, RUN, DONE.
  - Encoding: 2-bit, IDLE=0, RUN=1, DONE=2.
  - Encoding 3 is unreachable and recovers to IDLE on the next edge.
- IDLE/DONE with start=1:
  - mreg<=mcand; acc_hi<=0; acc_lo<=mplier; count<=0; go to RUN.
  - hi/lo are not changed on accept.
- RUN, each cycle:
  - add32 inputs: a=acc_hi, b=(acc_lo[0] ? mreg : 0).
  - carry = (a[31]&b[31]) | ((a[31]|b[31]) & ~sum[31]). Carry is derived this way because add32 has no carry-out.
  - {acc_hi,acc_lo} <= {carry,sum,acc_lo} >> 1, i.e. take the low 64 bits of the 65-bit right shift.
  - count<=count+1.
  - When count==31 on this edge: go to DONE and load hi<=next acc_hi, lo<=next acc_lo.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted (back-to-back).
  - Otherwise go to IDLE.
- Latency: start sampled at edge N → 32 RUN cycles → done=1 and hi/lo valid in the cycle after edge N+32.
- hi/lo hold their value until the next completed operation.
- start during RUN is ignored: no queueing, operands not re-captured.
- Arithmetic is unsigned only; MULT (signed) is out of scope for this block.
- add32 output is used only in RUN. In IDLE and DONE its inputs are still driven, but the result is discarded.

Decomposition:
- Shared package (mips_pkg): state encodings MS_IDLE/MS_RUN/MS_DONE, MULT_ITER=32, WORD_W=32.
- Sub-module: the existing add32, instantiated once.
- Everything else (FSM, counter, shift register, carry logic) stays in mult_seq.

Test Plan:
- Basic product: mcand=3, mplier=15, start 1 cycle → done pulse exactly 33 cycles after the start edge; hi=0x00000000, lo=0x0000002D; busy high for 32 cycles.
- Full-scale carry: 0xFFFFFFFF x 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Exercises the derived carry on every iteration.
- Zero and ones:
  - 0 x 0x12345678 → hi=0, lo=0.
  - 0x00000001 x 0x8000000F → hi=0, lo=0x8000000F.
  - 0x80000000 x 2 → hi=1, lo=0.
- Ignored start: start with 5x7, then raise start at cycle 10 of RUN with 9x9 → result still 0x23, done timing unchanged, one done pulse only.
- Back-to-back: hold start=1 through DONE with 6x7 then 0x10000 x 0x10000 → second op accepted in the DONE cycle.
  - First result lo=0x2A.
  - Second result: hi=1, lo=0.
  - Two done pulses 33 cycles apart.
- Reset mid-op: start 100x100, drop rst_n asynchronously (between clock edges) at RUN cycle 15 → busy, done, hi and lo all 0 immediately. After release, no done appears until a new start.
